serial_logic_unit: RTL and testbench

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/serial_logic_unit_if.sv | 25 ++
 rtl/serial_logic_unit.sv | 120 ++++++++++++
 tb/tb_serial_logic_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/serial_logic_unit_if.sv
// Bus bundle for serial_logic_unit: load/execute controls in, register views and status out.
interface serial_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             LoadA;
  logic             LoadB;
  logic             Execute;
  logic [WIDTH-1:0] Din;
  logic [2:0]       F;
  logic [1:0]       R;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Busy;
  logic             Done;

  modport master (
    output LoadA, LoadB, Execute, Din, F, R,
    input  Aval, Bval, Busy, Done
  );

  modport slave (
    input  LoadA, LoadB, Execute, Din, F, R,
    output Aval, Bval, Busy, Done
  );
endinterface

// File: rtl/serial_logic_unit.sv
// Two-register bit-serial logic unit: shifts A and B right WIDTH times, combining
// their LSBs through a selectable bitwise function and routing the result back in at the MSB.
module serial_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  serial_logic_unit_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Assert asynchronously, release two edges later so every register leaves reset together.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f_q, f_d;
  logic [1:0]       r_q, r_d;

  function automatic logic bit_fn(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'b000:  bit_fn = a & b;
      3'b001:  bit_fn = a | b;
      3'b010:  bit_fn = a ^ b;
      3'b011:  bit_fn = 1'b1;
      3'b100:  bit_fn = ~(a & b);
      3'b101:  bit_fn = ~(a | b);
      3'b110:  bit_fn = ~(a ^ b);
      default: bit_fn = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] route(input logic [1:0] sel, input logic a,
                                       input logic b, input logic f);
    case (sel)
      2'b00:   route = {a, b};
      2'b01:   route = {a, f};
      2'b10:   route = {f, b};
      default: route = {b, a};
    endcase
  endfunction

  logic       fbit;
  logic [1:0] new_ab;

  assign fbit   = bit_fn(f_q, a_q[0], b_q[0]);
  assign new_ab = route(r_q, a_q[0], b_q[0], fbit);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (bus.Execute) begin
          f_d     = bus.F;
          r_d     = bus.R;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          if (bus.LoadA) a_d = bus.Din;
          if (bus.LoadB) b_d = bus.Din;
        end
      end
      SHIFT: begin
        a_d   = {new_ab[1], a_q[WIDTH-1:1]};
        b_d   = {new_ab[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = HOLD;
      end
      HOLD: begin
        if (!bus.Execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      f_q     <= 3'b000;
      r_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      r_q     <= r_d;
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.Busy = (state_q == SHIFT);
  assign bus.Done = (state_q == HOLD);

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: vector table over functions/routings plus
// hand sequences for held Execute, mid-shift reset, input noise during shift and a 4-bit instance.
module tb_serial_logic_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_logic_unit_if #(.WIDTH(8)) bus8 ();
  serial_logic_unit_if #(.WIDTH(4)) bus4 ();

  serial_logic_unit #(.WIDTH(8)) dut8 (.Clk(clk), .Reset(rst_n), .bus(bus8));
  serial_logic_unit #(.WIDTH(4)) dut4 (.Clk(clk), .Reset(rst_n), .bus(bus4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;
    logic [1:0] r;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t vecs[12];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] b);
    bus8.LoadA = 1'b1; bus8.Din = a;
    cyc(1);
    bus8.LoadA = 1'b0; bus8.LoadB = 1'b1; bus8.Din = b;
    cyc(1);
    bus8.LoadB = 1'b0;
  endtask

  // Pulse Execute, count Busy samples until Done, then let the unit return to IDLE.
  task automatic run8(input logic [2:0] f, input logic [1:0] r, output int busy_cnt);
    bus8.F = f; bus8.R = r; bus8.Execute = 1'b1;
    cyc(1);
    bus8.Execute = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.Done) break;
      if (bus8.Busy) busy_cnt++;
      cyc(1);
    end
  endtask

  initial begin
    int bc;
    vecs[0]  = '{8'h0F, 8'h33, 3'b000, 2'b10, 8'h03, 8'h33};
    vecs[1]  = '{8'h0F, 8'h33, 3'b001, 2'b10, 8'h3F, 8'h33};
    vecs[2]  = '{8'h0F, 8'h33, 3'b010, 2'b10, 8'h3C, 8'h33};
    vecs[3]  = '{8'h0F, 8'h33, 3'b011, 2'b10, 8'hFF, 8'h33};
    vecs[4]  = '{8'h0F, 8'h33, 3'b100, 2'b10, 8'hFC, 8'h33};
    vecs[5]  = '{8'h0F, 8'h33, 3'b101, 2'b10, 8'hC0, 8'h33};
    vecs[6]  = '{8'h0F, 8'h33, 3'b110, 2'b10, 8'hC3, 8'h33};
    vecs[7]  = '{8'h0F, 8'h33, 3'b111, 2'b10, 8'h00, 8'h33};
    vecs[8]  = '{8'h0F, 8'h33, 3'b010, 2'b01, 8'h0F, 8'h3C};
    vecs[9]  = '{8'h0F, 8'h33, 3'b000, 2'b00, 8'h0F, 8'h33};
    vecs[10] = '{8'h0F, 8'h33, 3'b110, 2'b11, 8'h33, 8'h0F};
    vecs[11] = '{8'hA5, 8'h3C, 3'b101, 2'b01, 8'hA5, 8'h42};

    bus8.LoadA = 0; bus8.LoadB = 0; bus8.Execute = 0; bus8.Din = '0; bus8.F = '0; bus8.R = '0;
    bus4.LoadA = 0; bus4.LoadB = 0; bus4.Execute = 0; bus4.Din = '0; bus4.F = '0; bus4.R = '0;

    // Reset state, including loads attempted while reset is held.
    bus8.LoadA = 1'b1; bus8.Din = 8'h5A;
    cyc(2);
    check("reset_A", bus8.Aval, 8'h00);
    check("reset_B", bus8.Bval, 8'h00);
    check("reset_Busy", bus8.Busy, 1'b0);
    check("reset_Done", bus8.Done, 1'b0);
    bus8.LoadA = 1'b0;
    rst_n = 1'b1;
    cyc(3);

    for (int i = 0; i < 12; i++) begin
      load8(vecs[i].a, vecs[i].b);
      run8(vecs[i].f, vecs[i].r, bc);
      check($sformatf("vec%0d_Done", i), bus8.Done, 1'b1);
      check($sformatf("vec%0d_busycycles", i), bc, 8);
      check($sformatf("vec%0d_A", i), bus8.Aval, vecs[i].ea);
      check($sformatf("vec%0d_B", i), bus8.Bval, vecs[i].eb);
      cyc(1);
      check($sformatf("vec%0d_idle", i), {bus8.Busy, bus8.Done}, 2'b00);
    end

    // Intermediate values visible after the first shift.
    load8(8'h0F, 8'h33);
    bus8.F = 3'b000; bus8.R = 2'b00; bus8.Execute = 1'b1;
    cyc(1);
    bus8.Execute = 1'b0;
    cyc(1);
    check("mid_A", bus8.Aval, 8'h87);
    check("mid_B", bus8.Bval, 8'h99);
    cyc(10);

    // Execute held for 20 cycles: exactly one operation, Done holds until release.
    load8(8'h0F, 8'h33);
    bus8.F = 3'b010; bus8.R = 2'b11; bus8.Execute = 1'b1;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus8.Busy) bc++;
    end
    check("held_busycycles", bc, 8);
    check("held_Done", bus8.Done, 1'b1);
    check("held_A", bus8.Aval, 8'h33);
    check("held_B", bus8.Bval, 8'h0F);
    bus8.Execute = 1'b0;
    cyc(1);
    check("held_release", {bus8.Busy, bus8.Done}, 2'b00);

    // Reset in the middle of a shift.
    load8(8'h0F, 8'h33);
    bus8.F = 3'b000; bus8.R = 2'b10; bus8.Execute = 1'b1;
    cyc(1);
    bus8.Execute = 1'b0;
    cyc(3);
    check("abort_busy_before", bus8.Busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_A", bus8.Aval, 8'h00);
    check("abort_B", bus8.Bval, 8'h00);
    check("abort_status", {bus8.Busy, bus8.Done}, 2'b00);
    #2;
    rst_n = 1'b1;
    cyc(3);
    bus8.LoadA = 1'b1; bus8.Din = 8'hA5;
    cyc(1);
    bus8.LoadA = 1'b0;
    check("abort_reload_A", bus8.Aval, 8'hA5);
    check("abort_idle", {bus8.Busy, bus8.Done}, 2'b00);

    // Input noise during the shift must not disturb the result.
    load8(8'h0F, 8'h33);
    bus8.F = 3'b000; bus8.R = 2'b10; bus8.Execute = 1'b1;
    cyc(1);
    bus8.Execute = 1'b0;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      bus8.Din = 8'hFF;
      bus8.F = 3'(i + 3);
      bus8.R = 2'(i);
      bus8.LoadA = i[0];
      bus8.LoadB = ~i[0];
      if (bus8.Busy) bc++;
      cyc(1);
    end
    bus8.LoadA = 1'b0; bus8.LoadB = 1'b0;
    check("noise_busycycles", bc, 8);
    check("noise_Done", bus8.Done, 1'b1);
    check("noise_A", bus8.Aval, 8'h03);
    check("noise_B", bus8.Bval, 8'h33);
    cyc(1);

    // 4-bit instance.
    bus4.LoadA = 1'b1; bus4.Din = 4'hC;
    cyc(1);
    bus4.LoadA = 1'b0; bus4.LoadB = 1'b1; bus4.Din = 4'hA;
    cyc(1);
    bus4.LoadB = 1'b0;
    bus4.F = 3'b001; bus4.R = 2'b10; bus4.Execute = 1'b1;
    cyc(1);
    bus4.Execute = 1'b0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.Done) break;
      if (bus4.Busy) bc++;
      cyc(1);
    end
    check("w4_Done", bus4.Done, 1'b1);
    check("w4_busycycles", bc, 4);
    check("w4_A", bus4.Aval, 4'hE);
    check("w4_B", bus4.Bval, 4'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
